seg7_scan_rx: RTL and testbench
===============================

Name: seg7_scan_rx

Overview:
- Receiving end of the multiplexed digit bus (data[3:0] + sel[2:0]) driven by the counter/display-source blocks.
- Captures each (sel, data) pair into a per-digit register file.
- Independently scans the stored digits onto a common-anode 7-segment display: one-hot active-low anodes, active-low hex segments, and a programmable anti-ghosting blank window.

Parameters:
- NUM_DIGITS, 8, number of display digits (1..8); sel values >= NUM_DIGITS are ignored.
- SCAN_DIV, 100000, clk cycles each digit is held in the scan; must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each digit slot with all anodes off; must be < SCAN_DIV.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_sel/in_data for one cycle.
- in_sel  input  3  digit index to write.
- in_data  input  4  hex nibble for that digit.
- clear  input  1  one-cycle pulse; invalidates (blanks) all digits.
- an  output  NUM_DIGITS  anode enables, active-low, at most one bit low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- scan_idx  output  3  digit index currently being scanned (debug/verification).

Behaviour:
Reset (rst=1 at a clk edge):
- digit regs = 0, valid bits = 0, prescaler pcnt = 0, scan_idx = 0.
- an = all ones, seg = 7'h7F.
- rst overrides in_valid and clear in the same cycle.

Capture:
- At a clk edge with in_valid=1 and in_sel < NUM_DIGITS: digit[in_sel] <= in_data and vld[in_sel] <= 1.
- With in_sel >= NUM_DIGITS, the write is dropped silently.
- A repeated write to the same sel overwrites the digit; no handshake and no backpressure, so a write is accepted every cycle.

Clear:
- clear=1 forces all vld bits to 0; digit contents are retained.
- clear and in_valid in the same cycle: the clear applies first, then the write, so only the written digit ends up valid.

Prescaler and scan:
- pcnt counts 0..SCAN_DIV-1 and wraps.
- When pcnt == SCAN_DIV-1, scan_idx <= scan_idx+1, wrapping from NUM_DIGITS-1 to 0.
- scan_idx is updated in the same edge as the pcnt wrap.

Output stage (registered, evaluated from the current pcnt/scan_idx/regs, visible one cycle later):
- If pcnt < BLANK_CYCLES, or vld[scan_idx]=0: an = all ones, seg = 7'h7F.
- Otherwise: an = ~(1 << scan_idx) and seg = font(digit[scan_idx]).

Font (active-low hex):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Latency:
- A write becomes visible on seg 2 cycles after the in_valid edge, provided that digit is being scanned outside the blank window.
- A mid-slot write updates the displayed value immediately; the slot is not restarted.

Mid-operation reset:
- Any cycle of rst returns every register to its reset values.
- The scan restarts at digit 0 with pcnt = 0, so the first BLANK_CYCLES after reset are blank.

Decomposition:
- seg7_pkg:
  - 16-entry hex font constant.
  - SEG_OFF = 7'h7F and an AN_OFF helper.
  - Digit index width constant (3).
- Sub-module hex_to_seg7: purely combinational nibble-to-segment decode, instantiated once on the scan read path.
- Register file, prescaler and output registers stay in seg7_scan_rx.

Test Plan (bench params NUM_DIGITS=2, SCAN_DIV=4, BLANK_CYCLES=1):
- Reset, then idle 16 cycles -> an=2'b11 and seg=7'h7F throughout; scan_idx toggles every 4 cycles.
- Write sel=0 data=5, sel=1 data=A -> in slot 0 after the blank cycle: an=2'b10, seg=7'h12; in slot 1: an=2'b01, seg=7'h08; first pcnt cycle of each slot is blank.
- Write sel=3 data=7 -> no register change, display unchanged; write sel=0 data=F during slot 0 -> seg=7'h0E two cycles later.
- Same-cycle clear + write sel=1 data=2 -> digit 0 blank in its slot; digit 1 shows seg=7'h24.
- Sweep sel=0 over data 0..F -> seg matches the font table for every value.
- Assert rst for 1 cycle mid-slot 1 -> next cycle an=2'b11, scan_idx=0, and all digits remain blank until rewritten.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment digit receiver: hex font, blank codes
// and the digit index width.
package seg7_pkg;

    localparam int IDX_W = 3;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_rx_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decode.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_rx.sv
// Captures (sel, data) digit writes into a register file and scans the stored
// digits onto a common-anode display with a per-slot blank window.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2:0]            in_sel,
    input  logic [3:0]            in_data,
    input  logic                  clear,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic [IDX_W-1:0]      scan_idx
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]            digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] vld;
    logic [PW-1:0]         pcnt;

    logic [3:0]            cur_digit;
    logic                  cur_vld;
    logic [6:0]            font_seg;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;

    // Clear is applied before the write so a same-cycle write survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
        end else begin
            if (clear) vld <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (in_valid && in_sel == IDX_W'(i)) begin
                    digit[i] <= in_data;
                    vld[i]   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt     <= '0;
            scan_idx <= '0;
        end else if (pcnt == PW'(SCAN_DIV - 1)) begin
            pcnt     <= '0;
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_comb begin
        cur_digit = '0;
        cur_vld   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_digit = digit[i];
                cur_vld   = vld[i];
            end
        end
    end

    hex_to_seg7 u_font (
        .nibble (cur_digit),
        .seg    (font_seg)
    );

    always_comb begin
        an_d  = AN_OFF[NUM_DIGITS-1:0];
        seg_d = SEG_OFF;
        if (pcnt >= PW'(BLANK_CYCLES) && cur_vld) begin
            an_d  = ~(NUM_DIGITS'(1) << scan_idx);
            seg_d = font_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF[NUM_DIGITS-1:0];
            seg <= SEG_OFF;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed bench for seg7_scan_rx with NUM_DIGITS=2, SCAN_DIV=4, BLANK_CYCLES=1.
module tb_seg7_scan_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_sel = '0;
    logic [3:0] in_data = '0;
    logic       clear = 1'b0;
    logic [1:0] an;
    logic [6:0] seg;
    logic [2:0] scan_idx;

    int tests_run    = 0;
    int tests_failed = 0;
    int k            = 0;   // clk edges since the last reset edge

    // Shadow of the digit registers, updated after each write edge.
    logic [1:0] m_vld = '0;
    logic [3:0] m_dig [2] = '{4'h0, 4'h0};

    logic [6:0] font_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_rx #(
        .NUM_DIGITS   (2),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .clear    (clear),
        .an       (an),
        .seg      (seg),
        .scan_idx (scan_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        if (rst) k = 0;
        else k++;
        #1;
    endtask

    function automatic logic [1:0] exp_an(int kk);
        int p, i;
        if (kk == 0) return 2'b11;
        p = (kk - 1) % 4;
        i = ((kk - 1) / 4) % 2;
        if (p < 1 || !m_vld[i]) return 2'b11;
        return (i == 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [6:0] exp_seg(int kk);
        int p, i;
        if (kk == 0) return 7'h7F;
        p = (kk - 1) % 4;
        i = ((kk - 1) / 4) % 2;
        if (p < 1 || !m_vld[i]) return 7'h7F;
        return font_tab[m_dig[i]];
    endfunction

    function automatic logic [2:0] exp_idx(int kk);
        return 3'((kk / 4) % 2);
    endfunction

    task automatic write(input logic [2:0] sel, input logic [3:0] data, input logic clr);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        clear    = clr;
        step();
        if (clr) m_vld = '0;
        if (sel < 3'd2) begin
            m_dig[sel[0]] = data;
            m_vld[sel[0]] = 1'b1;
        end
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // Advance until the outputs reflect the given slot and pcnt phase.
    task automatic wait_out(input int idx, input int phase, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 9; n++) begin
            step();
            if (k > 0 && (k - 1) % 4 == phase && ((k - 1) / 4) % 2 == idx) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_vld = '0;
        tests_run++;
        if (an !== 2'b11 || seg !== 7'h7F || scan_idx !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state: an=%b seg=%h idx=%0d, want an=11 seg=7f idx=0", an, seg, scan_idx);
        end
        for (int n = 0; n < 16; n++) begin
            step();
            tests_run++;
            if (an !== 2'b11 || seg !== 7'h7F || scan_idx !== exp_idx(k)) begin
                tests_failed++;
                $display("FAIL idle_blank k=%0d: an=%b seg=%h idx=%0d, want an=11 seg=7f idx=%0d",
                         k, an, seg, scan_idx, exp_idx(k));
            end
        end
    endtask

    task automatic test_display();
        bit ok;
        write(3'd0, 4'h5, 1'b0);
        write(3'd1, 4'hA, 1'b0);
        for (int n = 0; n < 8; n++) begin
            step();
            tests_run++;
            if (an !== exp_an(k) || seg !== exp_seg(k) || scan_idx !== exp_idx(k)) begin
                tests_failed++;
                $display("FAIL display_scan k=%0d: an=%b seg=%h idx=%0d, want an=%b seg=%h idx=%0d",
                         k, an, seg, scan_idx, exp_an(k), exp_seg(k), exp_idx(k));
            end
        end
        wait_out(0, 0, ok);
        tests_run++;
        if (!ok || an !== 2'b11 || seg !== 7'h7F) begin
            tests_failed++;
            $display("FAIL slot0_blank: ok=%0d an=%b seg=%h, want an=11 seg=7f", ok, an, seg);
        end
        step();
        tests_run++;
        if (an !== 2'b10 || seg !== 7'h12) begin
            tests_failed++;
            $display("FAIL slot0_digit5: an=%b seg=%h, want an=10 seg=12", an, seg);
        end
        wait_out(1, 1, ok);
        tests_run++;
        if (!ok || an !== 2'b01 || seg !== 7'h08) begin
            tests_failed++;
            $display("FAIL slot1_digitA: ok=%0d an=%b seg=%h, want an=01 seg=08", ok, an, seg);
        end
    endtask

    task automatic test_drop_and_overwrite();
        bit ok;
        write(3'd3, 4'h7, 1'b0);
        for (int n = 0; n < 8; n++) begin
            step();
            tests_run++;
            if (an !== exp_an(k) || seg !== exp_seg(k)) begin
                tests_failed++;
                $display("FAIL drop_sel3 k=%0d: an=%b seg=%h, want an=%b seg=%h",
                         k, an, seg, exp_an(k), exp_seg(k));
            end
        end
        wait_out(0, 1, ok);
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = 4'hF;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (!ok || an !== 2'b10 || seg !== 7'h12) begin
            tests_failed++;
            $display("FAIL overwrite_pre: ok=%0d an=%b seg=%h, want an=10 seg=12", ok, an, seg);
        end
        m_dig[0] = 4'hF;
        step();
        tests_run++;
        if (an !== 2'b10 || seg !== 7'h0E) begin
            tests_failed++;
            $display("FAIL overwrite_midslot: an=%b seg=%h, want an=10 seg=0e", an, seg);
        end
    endtask

    task automatic test_clear_write();
        bit ok;
        write(3'd1, 4'h2, 1'b1);
        for (int n = 0; n < 8; n++) begin
            step();
            tests_run++;
            if (an !== exp_an(k) || seg !== exp_seg(k)) begin
                tests_failed++;
                $display("FAIL clear_write k=%0d: an=%b seg=%h, want an=%b seg=%h",
                         k, an, seg, exp_an(k), exp_seg(k));
            end
        end
        wait_out(0, 2, ok);
        tests_run++;
        if (!ok || an !== 2'b11 || seg !== 7'h7F) begin
            tests_failed++;
            $display("FAIL cleared_digit0: ok=%0d an=%b seg=%h, want an=11 seg=7f", ok, an, seg);
        end
        wait_out(1, 2, ok);
        tests_run++;
        if (!ok || an !== 2'b01 || seg !== 7'h24) begin
            tests_failed++;
            $display("FAIL written_digit1: ok=%0d an=%b seg=%h, want an=01 seg=24", ok, an, seg);
        end
    endtask

    task automatic test_font_sweep();
        bit ok;
        for (int d = 0; d < 16; d++) begin
            write(3'd0, 4'(d), 1'b0);
            wait_out(0, 2, ok);
            tests_run++;
            if (!ok || an !== 2'b10 || seg !== font_tab[d]) begin
                tests_failed++;
                $display("FAIL font_%0h: ok=%0d an=%b seg=%h, want an=10 seg=%h",
                         d, ok, an, seg, font_tab[d]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        wait_out(1, 1, ok);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_vld = '0;
        m_dig = '{4'h0, 4'h0};
        tests_run++;
        if (!ok || an !== 2'b11 || seg !== 7'h7F || scan_idx !== 3'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: ok=%0d an=%b seg=%h idx=%0d, want an=11 seg=7f idx=0",
                     ok, an, seg, scan_idx);
        end
        for (int n = 0; n < 16; n++) begin
            step();
            tests_run++;
            if (an !== 2'b11 || seg !== 7'h7F || scan_idx !== exp_idx(k)) begin
                tests_failed++;
                $display("FAIL post_reset_blank k=%0d: an=%b seg=%h idx=%0d, want an=11 seg=7f idx=%0d",
                         k, an, seg, scan_idx, exp_idx(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_display();
        test_drop_and_overwrite();
        test_clear_write();
        test_font_sweep();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
